upsample_2: RTL and testbench

UPSAMPLE_2 -- requirements
Module: upsample_2

---
 rtl/wavelet_pkg.sv | 12 +
 rtl/sample_fifo.sv | 55 +++++
 rtl/upsample_2.sv | 105 ++++++++++
 tb/tb_upsample_2.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wavelet_pkg.sv
// Shared constants for the wavelet datapath: output FSM encoding and default sample width.
package wavelet_pkg;

    localparam int ADC_WIDTH_DEFAULT = 14;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        EMIT_SAMPLE = 2'd1,
        EMIT_INSERT = 2'd2
    } up_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Power-of-two circular sample buffer with registered occupancy; pushes when full
// and pops when empty are ignored, so the pointers and level can never run away.
module sample_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && (level != LW'(DEPTH));
    assign do_pop   = pop && (level != '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are exactly AW bits wide, so natural overflow wraps them modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                level <= level + LW'(1);
            end else if (!do_push && do_pop) begin
                level <= level - LW'(1);
            end
        end
    end

endmodule

// File: rtl/upsample_2.sv
// Two-times upsampler: each buffered half-rate sample is followed by an inserted slot.
// Define UPSAMPLE_2_HOLD_EN for zero-order hold in the inserted slot; default is zero insertion.
module upsample_2
    import wavelet_pkg::*;
#(
    parameter int ADC_WIDTH  = ADC_WIDTH_DEFAULT,
    parameter int FIFO_DEPTH = 4,
    localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADC_WIDTH-1:0] adc_data_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [ADC_WIDTH-1:0] adc_data_out,
    output logic                 out_valid,
    output logic                 out_phase,
    output logic [LW-1:0]        fifo_level,
    output logic [15:0]          out_count
);

    up_state_t            state;
    logic                 push;
    logic                 pop;
    logic                 buf_nonempty;
    logic [ADC_WIDTH-1:0] head_data;
    logic [ADC_WIDTH-1:0] insert_data;

    // Handshake: a sample transfers on a rising edge where in_valid && in_ready;
    // in_ready depends only on the registered level, never on in_valid.
    assign in_ready     = (fifo_level != LW'(FIFO_DEPTH));
    assign push         = in_valid && in_ready;
    assign buf_nonempty = (fifo_level != '0);
    assign pop          = buf_nonempty && (state != EMIT_SAMPLE);

    sample_fifo #(
        .WIDTH (ADC_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (adc_data_in),
        .pop       (pop),
        .pop_data  (head_data),
        .level     (fifo_level)
    );

`ifdef UPSAMPLE_2_HOLD_EN
    logic [ADC_WIDTH-1:0] hold_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else if (pop) begin
            hold_q <= head_data;
        end
    end

    assign insert_data = hold_q;
`else
    assign insert_data = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            adc_data_out <= '0;
            out_valid    <= 1'b0;
            out_phase    <= 1'b0;
        end else begin
            case (state)
                EMIT_SAMPLE: begin
                    state        <= EMIT_INSERT;
                    adc_data_out <= insert_data;
                    out_valid    <= 1'b1;
                    out_phase    <= 1'b1;
                end
                default: begin
                    // IDLE and EMIT_INSERT both start a new pair whenever data is waiting.
                    if (buf_nonempty) begin
                        state        <= EMIT_SAMPLE;
                        adc_data_out <= head_data;
                        out_valid    <= 1'b1;
                        out_phase    <= 1'b0;
                    end else begin
                        state        <= IDLE;
                        adc_data_out <= '0;
                        out_valid    <= 1'b0;
                        out_phase    <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_count <= '0;
        end else if (out_valid) begin
            out_count <= out_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_upsample_2.sv
// Directed bench for upsample_2: latency, half/full-rate streams, extremes, reset mid-burst, counter wrap.
module tb_upsample_2;

    localparam int W  = 14;
    localparam int D  = 4;
    localparam int LW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  adc_data_in = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  adc_data_out;
    logic          out_valid;
    logic          out_phase;
    logic [LW-1:0] fifo_level;
    logic [15:0]   out_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];
    logic        mon_en = 1'b0;
    int          run = 0;
    int          max_run = 0;
    int          max_level = 0;
    logic        saw_full_block = 1'b0;
    logic        bad_ready = 1'b0;

    upsample_2 #(.ADC_WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .adc_data_in  (adc_data_in),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .adc_data_out (adc_data_out),
        .out_valid    (out_valid),
        .out_phase    (out_phase),
        .fifo_level   (fifo_level),
        .out_count    (out_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (out_valid) begin
            run = run + 1;
            if (run > max_run) max_run = run;
            if (mon_en) got_q.push_back({1'b0, out_phase, adc_data_out});
        end else begin
            run = 0;
        end
        if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
        if (fifo_level == LW'(D) && !in_ready) saw_full_block = 1'b1;
        if (fifo_level == LW'(D) && in_ready) bad_ready = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ins(input logic [W-1:0] v);
`ifdef UPSAMPLE_2_HOLD_EN
        return v;
`else
        return '0;
`endif
    endfunction

    function automatic logic [15:0] ent(input logic ph, input logic [W-1:0] v);
        return {1'b0, ph, v};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds in_valid with v until it is accepted on an edge; returns 1 time unit after that edge.
    task automatic push(input logic [W-1:0] v);
        logic taken;
        taken = 1'b0;
        adc_data_in = v;
        in_valid    = 1'b1;
        for (int i = 0; i < 50 && !taken; i++) begin
            taken = in_ready;
            tick(1);
        end
        if (!taken) check("push_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic compare_queue(input string tag);
        check({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_%0d", tag, i), (i < got_q.size()) ? got_q[i] : 16'hdead, exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [W-1:0] burst [10];
        logic [W-1:0] v;
        logic         found;
        logic         taken;

        // Reset state, including in_ready high while held in reset
        tick(3);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_data", adc_data_out, '0);
        check("rst_phase", out_phase, 1'b0);
        check("rst_level", fifo_level, '0);
        check("rst_count", out_count, 16'd0);
        check("rst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        tick(2);

        // Single sample and 1-cycle latency
        push(14'h0123);
        check("single_lat_valid", out_valid, 1'b0);
        check("single_lat_level", fifo_level, 1);
        tick(1);
        check("single_s_valid", out_valid, 1'b1);
        check("single_s_data", adc_data_out, 14'h0123);
        check("single_s_phase", out_phase, 1'b0);
        check("single_s_level", fifo_level, 0);
        tick(1);
        check("single_i_valid", out_valid, 1'b1);
        check("single_i_data", adc_data_out, ins(14'h0123));
        check("single_i_phase", out_phase, 1'b1);
        tick(1);
        check("single_idle_valid", out_valid, 1'b0);
        check("single_idle_data", adc_data_out, '0);
        check("single_count", out_count, 16'd2);
        tick(2);

        // Half-rate stream: contiguous output
        mon_en  = 1'b1;
        max_run = 0;
        for (int i = 1; i <= 4; i++) begin
            push(W'(i));
            tick(1);
            exp_q.push_back(ent(1'b0, W'(i)));
            exp_q.push_back(ent(1'b1, ins(W'(i))));
        end
        tick(6);
        check("half_run", max_run, 8);
        compare_queue("half");

        // Full-rate burst: in_valid held high, back-pressure at level 4
        max_run = 0;
        max_level = 0;
        saw_full_block = 1'b0;
        bad_ready = 1'b0;
        for (int i = 0; i < 10; i++) burst[i] = W'(16'h0100 + i * 37);
        for (int i = 0; i < 10; i++) begin
            push(burst[i]);
            if (i < 9) begin
                adc_data_in = burst[i + 1];
                in_valid = 1'b1;
            end
            exp_q.push_back(ent(1'b0, burst[i]));
            exp_q.push_back(ent(1'b1, ins(burst[i])));
        end
        tick(20);
        check("burst_max_level", max_level, D);
        check("burst_full_block", saw_full_block, 1'b1);
        check("burst_ready_when_full", bad_ready, 1'b0);
        check("burst_run", max_run, 20);
        compare_queue("burst");

        // Signed extremes pass bit-exact
        push(14'h2000);
        tick(1);
        push(14'h1FFF);
        tick(6);
        exp_q.push_back(ent(1'b0, 14'h2000));
        exp_q.push_back(ent(1'b1, ins(14'h2000)));
        exp_q.push_back(ent(1'b0, 14'h1FFF));
        exp_q.push_back(ent(1'b1, ins(14'h1FFF)));
        compare_queue("extreme");

        // Reset mid-burst while inserting with 3 entries buffered
        found = 1'b0;
        v = 14'h0300;
        adc_data_in = v;
        in_valid = 1'b1;
        for (int i = 0; i < 40 && !found; i++) begin
            if (out_valid && out_phase && fifo_level == 3) begin
                found = 1'b1;
            end else begin
                taken = in_ready;
                tick(1);
                if (taken) begin
                    v = v + 1'b1;
                    adc_data_in = v;
                end
            end
        end
        check("midrst_reached", found, 1'b1);
        adc_data_in = 14'h3AAA;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", out_valid, 1'b0);
        check("midrst_data", adc_data_out, '0);
        check("midrst_phase", out_phase, 1'b0);
        check("midrst_level", fifo_level, 0);
        check("midrst_count", out_count, 16'd0);
        check("midrst_ready", in_ready, 1'b1);
        tick(2);
        check("midrst_no_accept", fifo_level, 0);
        in_valid = 1'b0;
        got_q.delete();
        rst_n = 1'b1;
        tick(1);
        push(14'h0055);
        tick(4);
        exp_q.push_back(ent(1'b0, 14'h0055));
        exp_q.push_back(ent(1'b1, ins(14'h0055)));
        compare_queue("post_rst");

        // Counter wrap after 65536 outputs
        mon_en = 1'b0;
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        for (int i = 0; i < 32767; i++) begin
            push(W'(i));
            tick(1);
        end
        check("wrap_pre", out_count, 16'hFFFC);
        push(14'h1234);
        tick(5);
        check("wrap_count", out_count, 16'h0000);
        check("wrap_idle", out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
